// File: rtl/cpu_port_in.sv
// cpu_port_in: input side of the CPU ports. It synchronizes and debounces
// the 32 pins (P0..P3), returns the filtered state on the SFR bus, and
// latches P3 falling edges into write-1-to-clear flags that drive a
// maskable interrupt request.
// Optional feature macro: CPU_PIN_DBNC_EN (per-bit debounce counters).
// With the macro undefined, the filtered state follows sync2 every cycle.
module cpu_port_in #(
  parameter int unsigned DBNC_CYCLES = 16,
  parameter logic [7:0]  ADDR_P0     = 8'h80,
  parameter logic [7:0]  ADDR_P1     = 8'h90,
  parameter logic [7:0]  ADDR_P2     = 8'hA0,
  parameter logic [7:0]  ADDR_P3     = 8'hB0,
  parameter logic [7:0]  ADDR_PIN_IF = 8'hC0,
  parameter logic [7:0]  ADDR_PIN_IE = 8'hC1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] mem_wr_data_i,
  output logic [7:0] mem_rd_data_o,
  input  logic [7:0] mem_addr_i,
  input  logic       mem_wr_i,
  input  logic       mem_rd_i,
  input  logic [7:0] p0_in_i,
  input  logic [7:0] p1_in_i,
  input  logic [7:0] p2_in_i,
  input  logic [7:0] p3_in_i,
  output logic       irq_o
);

  localparam int unsigned NPIN = 32;

  // Reject out-of-range debounce lengths at elaboration.
  if (DBNC_CYCLES < 1 || DBNC_CYCLES > 255) begin : g_bad_dbnc
    $error("cpu_port_in: DBNC_CYCLES must be in 1..255");
  end

  logic [NPIN-1:0] pins_c;
  logic [NPIN-1:0] sync1_q, sync2_q;
  logic [NPIN-1:0] dbn_q, dbn_d;
  logic [7:0]      dbn_p3_q;
  logic [7:0]      if_q, if_d;
  logic [7:0]      ie_q, ie_d;
  logic [7:0]      rd_q, rd_d;
  logic [7:0]      fall_c;
  logic            wr_if_c, wr_ie_c;

  assign pins_c = {p3_in_i, p2_in_i, p1_in_i, p0_in_i};

  // Two-flop synchronizer; pins idle high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pins_c;
      sync2_q <= sync1_q;
    end
  end

`ifdef CPU_PIN_DBNC_EN
  localparam int unsigned CW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;

  logic [NPIN-1:0][CW-1:0] cnt_q, cnt_d;

  // Per-bit stability counter: accept sync2 after DBNC_CYCLES differing cycles.
  always_comb begin
    dbn_d = dbn_q;
    cnt_d = '0;
    for (int i = 0; i < NPIN; i++) begin
      if (sync2_q[i] != dbn_q[i]) begin
        if (cnt_q[i] == CW'(DBNC_CYCLES - 1)) begin
          dbn_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce counter storage; discarded on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No filtering: the debounced state is just the synchronized pin.
  always_comb begin
    dbn_d = sync2_q;
  end
`endif

  // Debounced state and the P3 copy used for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dbn_q    <= '1;
      dbn_p3_q <= '1;
    end else begin
      dbn_q    <= dbn_d;
      dbn_p3_q <= dbn_q[31:24];
    end
  end

  assign fall_c  = dbn_p3_q & ~dbn_q[31:24];
  assign wr_if_c = mem_wr_i && (mem_addr_i == ADDR_PIN_IF);
  assign wr_ie_c = mem_wr_i && (mem_addr_i == ADDR_PIN_IE);

  // Bus decode: writes win over reads; a new edge wins over a W1C clear.
  always_comb begin
    if_d = (if_q & ~(wr_if_c ? mem_wr_data_i : 8'h00)) | fall_c;
    ie_d = wr_ie_c ? mem_wr_data_i : ie_q;
    rd_d = rd_q;
    if (mem_rd_i && !mem_wr_i) begin
      case (mem_addr_i)
        ADDR_P0:     rd_d = dbn_q[7:0];
        ADDR_P1:     rd_d = dbn_q[15:8];
        ADDR_P2:     rd_d = dbn_q[23:16];
        ADDR_P3:     rd_d = dbn_q[31:24];
        ADDR_PIN_IF: rd_d = if_q;
        ADDR_PIN_IE: rd_d = ie_q;
        default:     rd_d = rd_q;
      endcase
    end
  end

  // SFR registers and registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      if_q <= '0;
      ie_q <= '0;
      rd_q <= '0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
      rd_q <= rd_d;
    end
  end

  assign mem_rd_data_o = rd_q;
  assign irq_o         = |(if_q & ie_q);

endmodule

// File: tb/tb_cpu_port_in.sv
// Bench for cpu_port_in: directed stimulus, a history-based reference model
// checked every cycle, and literal expectations at the key points.
module tb_cpu_port_in;

`ifdef CPU_PIN_DBNC_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif

  localparam logic [7:0] A_P0 = 8'h80, A_P1 = 8'h90, A_P2 = 8'hA0, A_P3 = 8'hB0;
  localparam logic [7:0] A_IF = 8'hC0, A_IE = 8'hC1, A_UNM = 8'h81;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data, rd_data, addr;
  logic       wr, rd;
  logic [7:0] p0, p1, p2, p3;
  logic       irq;

  int checks = 0;
  int errors = 0;

  cpu_port_in #(.DBNC_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mem_wr_data_i(wr_data), .mem_rd_data_o(rd_data),
    .mem_addr_i(addr), .mem_wr_i(wr), .mem_rd_i(rd),
    .p0_in_i(p0), .p1_in_i(p1), .p2_in_i(p2), .p3_in_i(p3), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pin level is accepted once the last W synchronized
  // samples all disagree with the accepted level.
  logic [31:0] m_hist [0:4];
  logic [31:0] m_dbn;
  logic [7:0]  m_p3p, m_if, m_ie, m_rd;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] nd;
    logic [7:0]  fall;
    bit          all_diff;
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) m_hist[k] <= '1;
      m_dbn   <= '1;
      m_p3p   <= '1;
      m_if    <= '0;
      m_ie    <= '0;
      m_rd    <= '0;
      m_valid <= 1'b1;
    end else begin
      fall = m_p3p & ~m_dbn[31:24];
      nd   = m_dbn;
      for (int b = 0; b < 32; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= W; k++) if (m_hist[k][b] == m_dbn[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_dbn[b];
      end
      if (rd && !wr) begin
        case (addr)
          A_P0: m_rd <= m_dbn[7:0];
          A_P1: m_rd <= m_dbn[15:8];
          A_P2: m_rd <= m_dbn[23:16];
          A_P3: m_rd <= m_dbn[31:24];
          A_IF: m_rd <= m_if;
          A_IE: m_rd <= m_ie;
          default: ;
        endcase
      end
      m_if  <= (m_if & ((wr && addr == A_IF) ? ~wr_data : 8'hFF)) | fall;
      if (wr && addr == A_IE) m_ie <= wr_data;
      m_p3p <= m_dbn[31:24];
      m_dbn <= nd;
      m_hist[0] <= {p3, p2, p1, p0};
      for (int k = 1; k < 5; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rd_data", rd_data, m_rd);
      chk("model_irq", {7'd0, irq}, {7'd0, |(m_if & m_ie)});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [7:0] a);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus_rd(a);
    chk(name, rd_data, exp);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = 8'h00; wr_data = 8'h00;
    p0 = 8'hFF; p1 = 8'hFF; p2 = 8'hFF; p3 = 8'hFF;
    idle(2);
    rst_n = 1'b1;

    // Reset state
    chk("reset_irq", {7'd0, irq}, 8'h00);
    chk("reset_rd_data", rd_data, 8'h00);
    rd_chk(A_P0, 8'hFF, "reset_p0");
    rd_chk(A_P1, 8'hFF, "reset_p1");
    rd_chk(A_P2, 8'hFF, "reset_p2");
    rd_chk(A_P3, 8'hFF, "reset_p3");
    rd_chk(A_IF, 8'h00, "reset_if");
    rd_chk(A_IE, 8'h00, "reset_ie");

    // Debounce latency: old value at edge W+1, new value visible from edge W+2
    p1 = 8'h5A;
    idle(W + 1);
    rd_chk(A_P1, 8'hFF, "p1_before_accept");
    rd_chk(A_P1, 8'h5A, "p1_after_accept");

    // 3-cycle glitch, read back-to-back throughout
    p1 = 8'h00;
    bus_rd(A_P1); bus_rd(A_P1); bus_rd(A_P1);
    p1 = 8'h5A;
    for (int i = 0; i < 8; i++) bus_rd(A_P1);
    rd_chk(A_P1, 8'h5A, "p1_after_glitch");

    // Falling edge on P3[2] with IE enabled
    bus_wr(A_IE, 8'h04);
    p3 = 8'hFB;
    idle(W + 2);
    chk("irq_before_flag_edge", {7'd0, irq}, 8'h00);
    idle(1);
    chk("irq_after_flag_edge", {7'd0, irq}, 8'h01);
    rd_chk(A_IF, 8'h04, "if_set");

    // W1C clear
    bus_wr(A_IF, 8'h04);
    chk("irq_after_clear", {7'd0, irq}, 8'h00);
    rd_chk(A_IF, 8'h00, "if_cleared");

    // Rising edge raises no flag
    p3 = 8'hFF;
    idle(W + 4);
    rd_chk(A_IF, 8'h00, "if_rising_ignored");
    chk("irq_rising_ignored", {7'd0, irq}, 8'h00);

    // Collision: set one flag, then clear it in the same cycle as a new fall
    p3 = 8'hFB; idle(W + 4);
    p3 = 8'hFF; idle(W + 4);
    p3 = 8'hFB;
    idle(W + 2);
    bus_wr(A_IF, 8'h04);
    chk("irq_collision", {7'd0, irq}, 8'h01);
    idle(1);
    rd_chk(A_IF, 8'h04, "if_collision");

    // Write beats read in the same cycle
    addr = A_IE; wr_data = 8'hFF; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("wr_beats_rd_hold", rd_data, 8'h04);
    rd_chk(A_IE, 8'hFF, "ie_written");
    bus_rd(A_UNM);
    chk("unmapped_rd_hold", rd_data, 8'hFF);
    bus_wr(A_UNM, 8'h00);
    bus_wr(A_P0, 8'h00);
    rd_chk(A_P0, 8'hFF, "p0_write_ignored");

    // 1-cycle glitch on P0: propagates only without debounce
    p0 = 8'h00;
    idle(1);
    p0 = 8'hFF;
    idle(2);
`ifdef CPU_PIN_DBNC_EN
    rd_chk(A_P0, 8'hFF, "p0_short_glitch");
`else
    rd_chk(A_P0, 8'h00, "p0_short_glitch");
`endif
    idle(4);
    rd_chk(A_P0, 8'hFF, "p0_glitch_settled");

    // Reset in the middle of a debounce count
    p2 = 8'h00;
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("irq_after_mid_reset", {7'd0, irq}, 8'h00);
    rd_chk(A_P2, 8'hFF, "p2_after_mid_reset");
    rd_chk(A_IE, 8'h00, "ie_after_mid_reset");
    idle(W + 3);
    rd_chk(A_P2, 8'h00, "p2_accepted_after_reset");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_port_in.md
# cpu_port_in

Input-direction companion to the CPU port output latches. It synchronizes and debounces the 32 external input pins (four 8-bit ports) and returns the filtered pin state to the CPU over the shared SFR memory bus. It also detects falling edges on P3 and raises a maskable interrupt request toward the interrupt controller. It sits beside the port output block on the same MEM_* bus; the top level muxes the two read-data outputs.

## Interface
- DBNC_CYCLES, 16, consecutive stable cycles required before a pin change is accepted; legal range 1..255.
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset; one clock, synchronous, active-low.
- MEM_WR_DATA  input  `CPU_DATA_WIDTH  SFR write data.
- MEM_RD_DATA  output  `CPU_DATA_WIDTH  registered SFR read data.
- MEM_ADDR  input  `CPU_ADDR_WIDTH  SFR address.
- MEM_WR  input  1  write strobe, one cycle per access.
- MEM_RD  input  1  read strobe, one cycle per access.
- P0_IN, P1_IN, P2_IN, P3_IN  input  `CPU_DATA_WIDTH each  asynchronous pin inputs.
- IRQ  output  1  port interrupt request, level.

## Operation
- Address map, using macros from qwic51_include.vh:
  - P0..P3: read-only; return debounced pin state.
  - PIN_IF: P3 falling-edge flags; writing 1 to a bit clears it (write-1-to-clear).
  - PIN_IE: interrupt enable; read/write.
- Synchronizer: each pin passes through 2 flops, sync1 then sync2.
- Debounce, per bit, counter width clog2(DBNC_CYCLES):
  - If sync2 != dbn and cnt == DBNC_CYCLES-1: dbn <= sync2, cnt <= 0.
  - Else if sync2 != dbn: cnt <= cnt+1.
  - Else: cnt <= 0.
  - A glitch shorter than DBNC_CYCLES cycles never reaches dbn.
- Edge detect:
  - Register dbn_p3_d <= dbn[P3].
  - IF[i] sets when dbn_p3_d[i] & ~dbn[P3][i].
  - Rising edges are ignored.
- IRQ = |(IF & IE), driven combinationally from registers.
- Bus priority:
  - MEM_WR beats MEM_RD in the same cycle; the read is dropped and MEM_RD_DATA holds.
  - A write to P0..P3 is ignored.
  - Read or write to an unmapped address: no effect; MEM_RD_DATA holds.
- Simultaneous IF set and W1C clear on the same bit: set wins, so the bit stays 1.

## Timing
- Reset values (RST_N low at an edge):
  - sync1, sync2, dbn, dbn_p3_d = 8'hFF per port (idle-high pins).
  - cnt = 0; IF = 0; IE = 0.
  - MEM_RD_DATA = 0; IRQ = 0.
- Pin-change latency, with edge 0 being the first edge capturing the new level into sync1:
  - sync2 updates at edge 1.
  - dbn updates at edge DBNC_CYCLES+1, provided the level holds through that edge.
- Edge-flag latency:
  - IF sets at edge DBNC_CYCLES+2.
  - IRQ is high in the cycle after that edge, if IE is set.
- Read latency: MEM_RD sampled at edge N; MEM_RD_DATA valid after edge N and held until the next accepted read.
- Write latency: PIN_IE / PIN_IF take effect at the sampling edge; IRQ reflects the new value in the following cycle.
- Back-to-back reads and writes on consecutive cycles are supported; there are no wait states.
- Reset mid-debounce: the count is discarded and dbn returns to FF.

## Configuration
- CPU_PIN_DBNC_EN:
  - Defined: per-bit debounce counters as above.
  - Undefined: counters are removed and dbn <= sync2 every cycle. Pin-change latency is fixed at edge 2, and DBNC_CYCLES is ignored.

## Test plan
All scenarios use DBNC_CYCLES=4 with CPU_PIN_DBNC_EN defined unless noted.
- Reset: assert RST_N low 1 cycle, then read P0..P3, PIN_IF, PIN_IE -> FF, FF, FF, FF, 00, 00; IRQ=0.
- Debounce: drive P1_IN 8'hFF->8'h5A and hold -> P1 read returns FF up to edge 4, 5A from edge 5. A 3-cycle pulse of P1_IN=00 -> P1 still reads 5A.
- Falling edge + IRQ:
  - Write PIN_IE=8'h04, then drop P3_IN[2] and hold -> PIN_IF reads 04 and IRQ=1 after edge 6.
  - Write PIN_IF=04 -> IF=00, IRQ=0 next cycle.
  - A rising edge on P3_IN[2] -> no flag.
- Collision: W1C write of PIN_IF=04 in the same cycle as a new P3[2] falling edge -> PIN_IF stays 04, IRQ stays 1.
- Bus priority: MEM_WR to PIN_IE=8'hFF and MEM_RD of P0 in the same cycle -> IE=FF, MEM_RD_DATA unchanged. A read of an unmapped address -> MEM_RD_DATA unchanged.
- Macro undefined: P0_IN FF->00 -> P0 reads 00 from edge 2; a 1-cycle glitch does propagate.
